// File: rtl/sonar_pkg.sv
// rtl/sonar_pkg.sv - shared state encoding and default timing for the sonar controller
package sonar_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_HOLDOFF   = 3'd4
  } sonar_state_t;

  localparam int DEF_CLK_PER_US = 50;
  localparam int DEF_TRIG_US    = 10;
  localparam int DEF_TIMEOUT_US = 30000;
  localparam int DEF_HOLDOFF_US = 60000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// rtl/us_tick_gen.sv - one-cycle microsecond tick from a clearable clk prescaler
module us_tick_gen #(
  parameter int CLK_PER_US = 50
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int W = (CLK_PER_US > 2) ? $clog2(CLK_PER_US) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_PER_US - 1);

  logic [W-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/sonar_ctrl.sv
// rtl/sonar_ctrl.sv - ultrasonic ranger controller: trigger pulse, echo width capture, holdoff
module sonar_ctrl
  import sonar_pkg::*;
#(
  parameter int CLK_PER_US = DEF_CLK_PER_US,
  parameter int TRIG_US    = DEF_TRIG_US,
  parameter int TIMEOUT_US = DEF_TIMEOUT_US,
  parameter int HOLDOFF_US = DEF_HOLDOFF_US
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        echo_in,
  output logic        trig_out,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] echo_us
);

  localparam int MAX_US = max3(TRIG_US, TIMEOUT_US, HOLDOFF_US);
  localparam int CW     = $clog2(MAX_US + 1);

  localparam logic [CW-1:0] TRIG_LAST    = CW'(TRIG_US - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_US - 1);
  localparam logic [CW-1:0] TIMEOUT_FULL = CW'(TIMEOUT_US);
  localparam logic [CW-1:0] HOLDOFF_LAST = CW'(HOLDOFF_US - 1);

  sonar_state_t  state, state_next;
  logic [CW-1:0] us_cnt;
  logic          echo_s1, echo_s2, echo_prev;
  logic          echo_rise, echo_fall;
  logic          tick, state_chg;
  logic          load_result, result_to;
  logic [31:0]   result_val;

  assign echo_rise = echo_s2 & ~echo_prev;
  assign echo_fall = ~echo_s2 & echo_prev;
  assign state_chg = (state_next != state);

  us_tick_gen #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (state_chg),
    .tick  (tick)
  );

  always_comb begin
    state_next  = state;
    load_result = 1'b0;
    result_to   = 1'b0;
    result_val  = '0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_TRIG;
      end
      S_TRIG: begin
        if (tick && us_cnt == TRIG_LAST) state_next = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (echo_rise) begin
          state_next = S_MEASURE;
        end else if (tick && us_cnt == TIMEOUT_LAST) begin
          state_next  = S_HOLDOFF;
          load_result = 1'b1;
          result_to   = 1'b1;
        end
      end
      S_MEASURE: begin
        // A falling edge wins over the width limit on the same cycle.
        if (echo_fall) begin
          state_next  = S_HOLDOFF;
          load_result = 1'b1;
          result_val  = 32'(us_cnt);
        end else if (us_cnt == TIMEOUT_FULL) begin
          state_next  = S_HOLDOFF;
          load_result = 1'b1;
          result_to   = 1'b1;
          result_val  = 32'(TIMEOUT_US);
        end
      end
      S_HOLDOFF: begin
        if (tick && us_cnt == HOLDOFF_LAST) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      us_cnt    <= '0;
      echo_s1   <= 1'b0;
      echo_s2   <= 1'b0;
      echo_prev <= 1'b0;
      trig_out  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      echo_us   <= '0;
    end else begin
      state     <= state_next;
      echo_s1   <= echo_in;
      echo_s2   <= echo_s1;
      echo_prev <= echo_s2;
      if (state_chg) begin
        us_cnt <= '0;
      end else if (tick && state != S_IDLE) begin
        us_cnt <= us_cnt + CW'(1);
      end
      trig_out <= (state_next == S_TRIG);
      busy     <= (state_next != S_IDLE);
      done     <= load_result;
      if (load_result) begin
        timeout <= result_to;
        echo_us <= result_val;
      end
    end
  end

endmodule

// File: tb/tb_sonar_ctrl.sv
// tb/tb_sonar_ctrl.sv - directed self-checking bench for sonar_ctrl
module tb_sonar_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        echo_in;
  logic        trig_out;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] echo_us;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sonar_ctrl #(
    .CLK_PER_US (4),
    .TRIG_US    (10),
    .TIMEOUT_US (100),
    .HOLDOFF_US (20)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .echo_in  (echo_in),
    .trig_out (trig_out),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .echo_us  (echo_us)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge, then count how many cycles trig_out stays high.
  task automatic do_trigger(input string tag, output int trig_cycles);
    chk({tag, " busy before start"}, busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, " busy after start"}, busy, 1);
    trig_cycles = trig_out ? 1 : 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (!trig_out) break;
      trig_cycles++;
    end
  endtask

  task automatic wait_done(input string tag, input int limit, output int cyc);
    bit found;
    found = 1'b0;
    cyc = 0;
    for (int i = 0; i < limit; i++) begin
      step();
      cyc++;
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, " done seen"}, found, 1);
  endtask

  task automatic wait_idle(input int limit, output int cyc, output int pulses);
    cyc = 0;
    pulses = 0;
    while (busy && cyc < limit) begin
      step();
      cyc++;
      if (done) pulses++;
    end
  endtask

  int tc, cyc, pulses, ndone;

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    echo_in = 1'b0;
    steps(3);
    chk("rst trig_out", trig_out, 0);
    chk("rst busy",     busy,     0);
    chk("rst done",     done,     0);
    chk("rst timeout",  timeout,  0);
    chk("rst echo_us",  echo_us,  0);
    reset = 1'b1;
    steps(2);

    // Normal 23 us echo.
    do_trigger("A", tc);
    chk("A trig cycles", tc, 40);
    chk("A busy in wait", busy, 1);
    steps(8);
    echo_in = 1'b1;
    steps(92);
    echo_in = 1'b0;
    wait_done("A", 20, cyc);
    chk("A echo_us range", (echo_us >= 22 && echo_us <= 24), 1);
    chk("A timeout", timeout, 0);
    wait_idle(300, cyc, pulses);
    chk("A holdoff cycles", cyc, 80);
    chk("A extra done", pulses, 0);

    // No echo at all.
    do_trigger("B", tc);
    chk("B trig cycles", tc, 40);
    wait_done("B", 1000, cyc);
    chk("B timeout latency", cyc, 400);
    chk("B timeout", timeout, 1);
    chk("B echo_us", echo_us, 0);
    wait_idle(300, cyc, pulses);
    chk("B holdoff cycles", cyc, 80);

    // Echo rises and never falls.
    do_trigger("C", tc);
    steps(8);
    echo_in = 1'b1;
    wait_done("C", 1000, cyc);
    chk("C timeout", timeout, 1);
    chk("C echo_us", echo_us, 100);
    wait_idle(300, cyc, pulses);
    chk("C echo_us held", echo_us, 100);
    chk("C busy idle", busy, 0);

    // Echo already high on entry: no true rising edge, so it times out.
    do_trigger("D", tc);
    wait_done("D", 1000, cyc);
    chk("D timeout", timeout, 1);
    chk("D echo_us", echo_us, 0);
    echo_in = 1'b0;
    wait_idle(300, cyc, pulses);
    chk("D extra done", pulses, 0);
    steps(4);

    // start pressed during MEASURE and HOLDOFF is ignored.
    do_trigger("E", tc);
    steps(8);
    echo_in = 1'b1;
    steps(20);
    start = 1'b1;
    steps(3);
    start = 1'b0;
    steps(17);
    echo_in = 1'b0;
    ndone = 0;
    for (int i = 0; i < 200; i++) begin
      if (i == 20) start = 1'b1;
      if (i == 22) start = 1'b0;
      step();
      if (done) ndone++;
    end
    chk("E done pulses", ndone, 1);
    chk("E echo_us range", (echo_us >= 9 && echo_us <= 11), 1);
    chk("E timeout", timeout, 0);
    chk("E busy after", busy, 0);

    // Reset in the middle of MEASURE aborts immediately.
    do_trigger("F", tc);
    steps(8);
    echo_in = 1'b1;
    steps(20);
    reset = 1'b0;
    #1;
    chk("F trig_out", trig_out, 0);
    chk("F busy",     busy,     0);
    chk("F done",     done,     0);
    chk("F timeout",  timeout,  0);
    chk("F echo_us",  echo_us,  0);
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done || busy) ndone++;
    end
    chk("F quiet in reset", ndone, 0);
    echo_in = 1'b0;
    reset = 1'b1;
    steps(3);
    chk("F idle after release", busy, 0);
    do_trigger("G", tc);
    chk("G trig cycles", tc, 40);
    steps(8);
    echo_in = 1'b1;
    steps(92);
    echo_in = 1'b0;
    wait_done("G", 20, cyc);
    chk("G echo_us range", (echo_us >= 22 && echo_us <= 24), 1);
    chk("G timeout", timeout, 0);
    wait_idle(300, cyc, pulses);
    chk("G holdoff cycles", cyc, 80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
